// File: rtl/tty_kbd_port.sv
// tty_kbd_port: CPU IO-bus peripheral with two devices.
//   - TTY output FIFO (address TTY_ADDR): OUT data writes push a byte; the
//     display consumes the head with ack_pulse.
//   - Keyboard input latch (address KBD_ADDR): key_pulse latches sw; an IN
//     data cycle returns the byte on bus_out and clears kbd_full when io_e falls.
// Ports:
//   CLK, reset            board clock, synchronous active-high reset
//   io_s, io_e            CPU strobes (asynchronous, synchronized here)
//   io_da, io_io          1=address/0=data phase, 1=OUT/0=IN
//   bus_in, bus_out       CPU bus in, value ORed onto the CPU bus (0 when idle)
//   sw, key_pulse         keyboard data source and its latch pulse
//   ack_pulse             display consumed FIFO head
//   tty_byte, tty_valid   FIFO head byte (0 when empty), FIFO non-empty
//   tty_level             FIFO occupancy 0..DEPTH
//   overflow              sticky: an OUT to the TTY was dropped
//   kbd_full              keyboard latch holds an unread byte
module tty_kbd_port #(
    parameter logic [7:0] TTY_ADDR = 8'h00,
    parameter logic [7:0] KBD_ADDR = 8'h01,
    parameter int         DEPTH    = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       io_s,
    input  logic       io_e,
    input  logic       io_da,
    input  logic       io_io,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    input  logic [7:0] sw,
    input  logic       key_pulse,
    input  logic       ack_pulse,
    output logic [7:0] tty_byte,
    output logic       tty_valid,
    output logic [4:0] tty_level,
    output logic       overflow,
    output logic       kbd_full
);

    localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] LVL_FULL = 5'(DEPTH);

    // Strobe synchronizers: meta -> sync, plus one delayed copy for edges.
    logic s_meta_q, s_sync_q, s_prev_q;
    logic e_meta_q, e_sync_q, e_prev_q;

    logic [7:0]    dev_sel_q, dev_sel_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    kbd_data_q, kbd_data_d;
    logic          kbd_full_q, kbd_full_d;
    logic [7:0]    mem_q [DEPTH];

    logic s_rise, e_fall;
    logic push, pop, full, wr_en, drop, kbd_rd_done, kbd_drive;

    always_ff @(posedge CLK) begin
        if (reset) begin
            s_meta_q <= 1'b0;
            s_sync_q <= 1'b0;
            s_prev_q <= 1'b0;
            e_meta_q <= 1'b0;
            e_sync_q <= 1'b0;
            e_prev_q <= 1'b0;
        end else begin
            s_meta_q <= io_s;
            s_sync_q <= s_meta_q;
            s_prev_q <= s_sync_q;
            e_meta_q <= io_e;
            e_sync_q <= e_meta_q;
            e_prev_q <= e_sync_q;
        end
    end

    assign s_rise = s_sync_q & ~s_prev_q;
    assign e_fall = ~e_sync_q & e_prev_q;

    assign full  = (level_q == LVL_FULL);
    assign push  = s_rise & ~io_da & io_io & (dev_sel_q == TTY_ADDR);
    assign pop   = ack_pulse & (level_q != 5'd0);
    // A push into a full FIFO still lands when the head is popped in the
    // same cycle: the freed slot is exactly the one the write pointer hits.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    assign kbd_rd_done = e_fall & ~io_da & ~io_io & (dev_sel_q == KBD_ADDR);

    always_comb begin
        dev_sel_d  = dev_sel_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q | drop;
        kbd_data_d = kbd_data_q;
        kbd_full_d = kbd_full_q;

        if (s_rise && io_da && io_io)
            dev_sel_d = bus_in;

        if (wr_en)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);

        case ({wr_en, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase

        // A new key arriving as the CPU finishes its read keeps the latch full.
        if (key_pulse) begin
            kbd_data_d = sw;
            kbd_full_d = 1'b1;
        end else if (kbd_rd_done) begin
            kbd_full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            dev_sel_q  <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= 5'd0;
            ovf_q      <= 1'b0;
            kbd_data_q <= 8'h00;
            kbd_full_q <= 1'b0;
        end else begin
            dev_sel_q  <= dev_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            kbd_data_q <= kbd_data_d;
            kbd_full_q <= kbd_full_d;
        end
    end

    // FIFO storage holds data only; occupancy lives in the control registers.
    always_ff @(posedge CLK) begin
        if (wr_en && !reset)
            mem_q[wr_ptr_q] <= bus_in;
    end

    // Outputs are forced low while reset is held, not just after its edge.
    assign kbd_drive = ~reset & e_sync_q & ~io_da & ~io_io &
                       (dev_sel_q == KBD_ADDR) & kbd_full_q;
    assign bus_out   = kbd_drive ? kbd_data_q : 8'h00;
    assign tty_valid = ~reset & (level_q != 5'd0);
    assign tty_level = reset ? 5'd0 : level_q;
    assign tty_byte  = tty_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow  = ~reset & ovf_q;
    assign kbd_full  = ~reset & kbd_full_q;

endmodule

// File: tb/tb_tty_kbd_port.sv
module tb_tty_kbd_port;

    localparam int         DEPTH = 8;
    localparam logic [7:0] TTY   = 8'h00;
    localparam logic [7:0] KBD   = 8'h01;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       io_s = 1'b0, io_e = 1'b0, io_da = 1'b0, io_io = 1'b0;
    logic [7:0] bus_in = 8'h00, sw = 8'h00;
    logic       key_pulse = 1'b0, ack_pulse = 1'b0;
    logic [7:0] bus_out, tty_byte;
    logic       tty_valid, overflow, kbd_full;
    logic [4:0] tty_level;

    tty_kbd_port #(.TTY_ADDR(TTY), .KBD_ADDR(KBD), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .io_s(io_s), .io_e(io_e), .io_da(io_da),
        .io_io(io_io), .bus_in(bus_in), .bus_out(bus_out), .sw(sw),
        .key_pulse(key_pulse), .ack_pulse(ack_pulse), .tty_byte(tty_byte),
        .tty_valid(tty_valid), .tty_level(tty_level), .overflow(overflow),
        .kbd_full(kbd_full)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: FIFO as a queue, flags as plain bits.
    logic [7:0] q[$];
    bit         m_ovf = 0;
    bit         m_kfull = 0;
    logic [7:0] m_kdata = 8'h00;
    logic [7:0] m_dev = 8'h00;

    wire [15:0] status = {tty_valid, tty_level, tty_byte, overflow, kbd_full};

    function automatic logic [15:0] exp_status();
        logic [7:0] hb;
        logic       v;
        hb = (q.size() > 0) ? q[0] : 8'h00;
        v  = (q.size() > 0);
        return {v, 5'(q.size()), hb, m_ovf, m_kfull};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // OUT cycle: io_s high long enough for the synchronizer, then an io_e pulse.
    // with_ack lines ack_pulse up with the cycle in which the push happens.
    task automatic strobe_out(input logic da, input logic [7:0] val, input bit with_ack);
        io_da = da; io_io = 1'b1; bus_in = val; io_s = 1'b1;
        tick(2);
        if (with_ack) ack_pulse = 1'b1;
        tick(1);
        ack_pulse = 1'b0;
        tick(1);
        io_s = 1'b0;
        tick(3);
        io_e = 1'b1;
        tick(3);
        io_e = 1'b0;
        tick(4);
    endtask

    task automatic out_addr(input logic [7:0] a);
        strobe_out(1'b1, a, 1'b0);
        m_dev = a;
    endtask

    task automatic out_data(input logic [7:0] d, input bit with_ack);
        bit was_full, popped;
        was_full = (q.size() == DEPTH);
        popped   = with_ack && (q.size() > 0);
        strobe_out(1'b0, d, with_ack);
        if (m_dev == TTY) begin
            if (popped) void'(q.pop_front());
            if (!was_full || popped) q.push_back(d);
            else m_ovf = 1;
        end else if (popped) begin
            void'(q.pop_front());
        end
    endtask

    task automatic ack();
        ack_pulse = 1'b1;
        tick(1);
        ack_pulse = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic key(input logic [7:0] v);
        sw = v; key_pulse = 1'b1;
        tick(1);
        key_pulse = 1'b0;
        m_kdata = v; m_kfull = 1;
    endtask

    task automatic in_read(output logic [7:0] seen);
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        tick(3);
        seen = bus_out;
        io_e = 1'b0;
        tick(4);
        if (m_dev == KBD) m_kfull = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
        tick(1);
        q.delete(); m_ovf = 0; m_kfull = 0; m_kdata = 8'h00; m_dev = 8'h00;
    endtask

    task automatic test_reset();
        tick(3);
        n_total++;
        if (status !== 16'h0000) $display("FAIL reset_status got %h want 0000", status);
        else n_pass++;
        n_total++;
        if (bus_out !== 8'h00) $display("FAIL reset_bus_out got %h want 00", bus_out);
        else n_pass++;
        sw = 8'hC3; key_pulse = 1'b1;
        tick(1);
        key_pulse = 1'b0;
        reset = 1'b0;
        tick(2);
        n_total++;
        if (kbd_full !== 1'b0) $display("FAIL reset_key_ignored got %b want 0", kbd_full);
        else n_pass++;
    endtask

    task automatic test_tty_basic();
        out_addr(TTY);
        out_data(8'h41, 0);
        out_data(8'h42, 0);
        n_total++;
        if ({tty_valid, tty_byte, tty_level} !== {1'b1, 8'h41, 5'd2})
            $display("FAIL tty_two_bytes got v=%b b=%h l=%0d want v=1 b=41 l=2", tty_valid, tty_byte, tty_level);
        else n_pass++;
        ack();
        n_total++;
        if ({tty_byte, tty_level} !== {8'h42, 5'd1})
            $display("FAIL tty_after_ack got b=%h l=%0d want b=42 l=1", tty_byte, tty_level);
        else n_pass++;
        ack();
        ack();
        n_total++;
        if (status !== exp_status()) $display("FAIL tty_ack_empty got %h want %h", status, exp_status());
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset(2);
        out_addr(TTY);
        for (int i = 1; i <= 9; i++) out_data(8'(i), 0);
        n_total++;
        if ({tty_level, overflow} !== {5'd8, 1'b1})
            $display("FAIL ovf_full got l=%0d o=%b want l=8 o=1", tty_level, overflow);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            n_total++;
            if (tty_byte !== 8'(i)) $display("FAIL ovf_drain[%0d] got %h want %h", i, tty_byte, 8'(i));
            else n_pass++;
            ack();
        end
        n_total++;
        if ({tty_valid, overflow} !== 2'b01)
            $display("FAIL ovf_sticky got v=%b o=%b want v=0 o=1", tty_valid, overflow);
        else n_pass++;
    endtask

    task automatic test_full_push_ack();
        logic [7:0] want [8];
        do_reset(2);
        out_addr(TTY);
        for (int i = 1; i <= 8; i++) out_data(8'(i), 0);
        out_data(8'h55, 1);
        n_total++;
        if ({tty_level, overflow} !== {5'd8, 1'b0})
            $display("FAIL full_push_ack got l=%0d o=%b want l=8 o=0", tty_level, overflow);
        else n_pass++;
        for (int i = 0; i < 7; i++) want[i] = 8'(i + 2);
        want[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (tty_byte !== want[i]) $display("FAIL full_push_ack_drain[%0d] got %h want %h", i, tty_byte, want[i]);
            else n_pass++;
            ack();
        end
    endtask

    task automatic test_kbd();
        logic [7:0] seen;
        do_reset(2);
        key(8'h37);
        out_addr(KBD);
        in_read(seen);
        n_total++;
        if (seen !== 8'h37) $display("FAIL kbd_read got %h want 37", seen);
        else n_pass++;
        n_total++;
        if ({kbd_full, bus_out} !== {1'b0, 8'h00})
            $display("FAIL kbd_after_read got f=%b bus=%h want f=0 bus=00", kbd_full, bus_out);
        else n_pass++;
        key(8'h11);
        key(8'h22);
        in_read(seen);
        n_total++;
        if (seen !== 8'h22) $display("FAIL kbd_overwrite got %h want 22", seen);
        else n_pass++;
        // Key arrives in the very cycle the read completes: latch stays full.
        key(8'h5E);
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        tick(3);
        io_e = 1'b0;
        tick(2);
        sw = 8'h99; key_pulse = 1'b1;
        tick(1);
        key_pulse = 1'b0;
        tick(2);
        m_kdata = 8'h99; m_kfull = 1;
        n_total++;
        if (kbd_full !== 1'b1) $display("FAIL kbd_key_wins got %b want 1", kbd_full);
        else n_pass++;
        in_read(seen);
        n_total++;
        if (seen !== 8'h99) $display("FAIL kbd_key_wins_data got %h want 99", seen);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        bit bad;
        do_reset(2);
        key(8'h5A);
        out_addr(8'h05);
        out_data(8'hAA, 0);
        n_total++;
        if ({tty_valid, tty_level} !== {1'b0, 5'd0})
            $display("FAIL unmapped_push got v=%b l=%0d want v=0 l=0", tty_valid, tty_level);
        else n_pass++;
        bad = 0;
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus_out !== 8'h00) bad = 1;
        end
        io_e = 1'b0;
        tick(5);
        n_total++;
        if (bad) $display("FAIL unmapped_bus_out got nonzero want 00");
        else n_pass++;
        n_total++;
        if (kbd_full !== 1'b1) $display("FAIL unmapped_kbd_kept got %b want 1", kbd_full);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] seen;
        do_reset(2);
        out_addr(TTY);
        for (int i = 1; i <= 9; i++) out_data(8'(i + 8'h20), 0);
        for (int i = 0; i < 6; i++) ack();
        key(8'h3C);
        n_total++;
        if (status !== exp_status()) $display("FAIL mid_pre got %h want %h", status, exp_status());
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({status, bus_out} !== 24'h0) $display("FAIL mid_during got %h/%h want 0000/00", status, bus_out);
        else n_pass++;
        tick(1);
        reset = 1'b0;
        tick(1);
        q.delete(); m_ovf = 0; m_kfull = 0; m_kdata = 8'h00; m_dev = 8'h00;
        n_total++;
        if (status !== 16'h0000) $display("FAIL mid_after got %h want 0000", status);
        else n_pass++;
        // dev_sel is back at 0, which is the TTY address.
        out_data(8'h77, 0);
        n_total++;
        if ({tty_valid, tty_byte, tty_level} !== {1'b1, 8'h77, 5'd1})
            $display("FAIL mid_devsel got v=%b b=%h l=%0d want v=1 b=77 l=1", tty_valid, tty_byte, tty_level);
        else n_pass++;
        in_read(seen);
        n_total++;
        if (seen !== 8'h00) $display("FAIL mid_no_kbd got %h want 00", seen);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] seen, want_bus;
        int r;
        do_reset(2);
        out_addr(TTY);
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                out_data(8'($urandom), r == 4);
            end else if (r <= 6) begin
                ack();
            end else if (r == 7) begin
                key(8'($urandom));
            end else if (r == 8) begin
                out_addr(KBD);
                want_bus = m_kfull ? m_kdata : 8'h00;
                in_read(seen);
                n_total++;
                if (seen !== want_bus) $display("FAIL rand_bus[%0d] got %h want %h", n, seen, want_bus);
                else n_pass++;
                out_addr(TTY);
            end else begin
                tick(1);
            end
            n_total++;
            if (status !== exp_status()) $display("FAIL rand_status[%0d] got %h want %h", n, status, exp_status());
            else n_pass++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tty_basic();
        test_overflow();
        test_full_push_ack();
        test_kbd();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tty_kbd_port.md
TTY_KBD_PORT -- requirements
Module: tty_kbd_port

Interface
REQ-001 Parameter TTY_ADDR, default 8'h00, IO device address of the TTY output FIFO.
REQ-002 Parameter KBD_ADDR, default 8'h01, IO device address of the keyboard input latch.
REQ-003 Parameter DEPTH, default 8, TTY FIFO entries; power of two, 2 to 16.
REQ-004 CLK  input  1  board clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 io_s  input  1  CPU IO set strobe, level, asynchronous to CLK.
REQ-007 io_e  input  1  CPU IO enable strobe, level, asynchronous to CLK.
REQ-008 io_da  input  1  1 = address phase, 0 = data phase.
REQ-009 io_io  input  1  1 = OUT (CPU to device), 0 = IN (device to CPU).
REQ-010 bus_in  input  8  CPU bus value.
REQ-011 bus_out  output  8  value ORed onto the CPU bus; 0 when not driving.
REQ-012 sw  input  8  keyboard data source (board switches).
REQ-013 key_pulse  input  1  one-CLK pulse, already debounced; latches sw.
REQ-014 ack_pulse  input  1  one-CLK pulse; display has consumed the FIFO head.
REQ-015 tty_byte  output  8  FIFO head byte; 0 when FIFO empty.
REQ-016 tty_valid  output  1  FIFO non-empty.
REQ-017 tty_level  output  5  FIFO occupancy, 0..DEPTH.
REQ-018 overflow  output  1  sticky flag: an OUT to the TTY was dropped.
REQ-019 kbd_full  output  1  keyboard latch holds an unread byte.

Function
REQ-020 io_s and io_e shall each pass through a 2-flop synchronizer; the rising and falling edges are detected on the synchronized signals (s_rise, e_fall).
REQ-021 Address select: on s_rise with io_da=1, io_io=1, dev_sel shall load bus_in sampled in the same cycle as s_rise.
REQ-022 TTY write: on s_rise with io_da=0, io_io=1, dev_sel==TTY_ADDR, bus_in shall be pushed to the FIFO tail.
REQ-023 FIFO full on a push without a simultaneous pop: byte discarded, level unchanged, overflow set to 1 and held until reset.
REQ-024 Push and ack_pulse in the same cycle: both take effect; level unchanged (including when full: no overflow).
REQ-025 ack_pulse while FIFO empty: ignored.
REQ-026 tty_byte, tty_valid and tty_level shall reflect FIFO state registered; a push is visible one CLK after s_rise is detected.
REQ-027 Read/write pointers shall wrap modulo DEPTH; level shall be its own counter, not derived from pointer difference.
REQ-028 Keyboard latch: key_pulse loads sw into kbd_data and sets kbd_full; a key_pulse while kbd_full=1 overwrites kbd_data.
REQ-029 bus_out shall equal kbd_data while synchronized io_e=1, io_da=0, io_io=0, dev_sel==KBD_ADDR and kbd_full=1; 8'h00 otherwise (combinational from registered state).
REQ-030 On e_fall with io_da=0, io_io=0, dev_sel==KBD_ADDR, kbd_full shall clear; key_pulse in the same cycle wins (kbd_full stays 1, new data loaded).
REQ-031 Strobes while dev_sel matches neither address shall have no effect.

Reset
REQ-032 reset shall clear dev_sel, FIFO pointers, tty_level, overflow, kbd_data, kbd_full and the synchronizer flops to 0.
REQ-033 During reset all outputs shall be 0; strobes and pulses in a reset cycle are ignored.
REQ-034 Reset mid-operation shall discard FIFO contents and any pending keyboard byte.

Verification
REQ-035 OUT addr 8'h00, then OUT data 8'h41, 8'h42 -> tty_valid=1, tty_byte=8'h41, tty_level=2; ack_pulse -> tty_byte=8'h42, level=1.
REQ-036 Nine OUT data writes (8'h01..8'h09) to TTY with no ack -> tty_level=8, overflow=1, acks then yield 8'h01..8'h08, 8'h09 absent.
REQ-037 FIFO full, push 8'h55 with ack_pulse in same cycle -> level stays 8, overflow stays 0, 8'h55 is last entry.
REQ-038 sw=8'h37, key_pulse, OUT addr 8'h01, IN data -> bus_out=8'h37 while io_e high, kbd_full=0 after io_e falls, bus_out=0 after.
REQ-039 OUT addr 8'h05 then OUT data 8'hAA and IN data -> FIFO empty, bus_out=0 throughout.
REQ-040 Three bytes in FIFO, kbd_full=1, assert reset one CLK -> tty_level=0, tty_valid=0, kbd_full=0, overflow=0, dev_sel=0.
